// File: rtl/dcache_pkg.sv
// Shared types and geometry for the L1 dcache SRAM front end.
// Types only; no latency or flow control of its own.
// Not applicable: holds no logic.
package dcache_pkg;

    localparam int DCACHE_INDEX_WIDTH = 12;
    localparam int DCACHE_TAG_WIDTH   = 44;
    localparam int DCACHE_LINE_WIDTH  = 128;
    localparam int DCACHE_SET_ASSOC   = 8;

    typedef struct packed {
        logic [DCACHE_TAG_WIDTH-1:0]  tag;
        logic [DCACHE_LINE_WIDTH-1:0] data;
        logic                         dirty;
        logic                         valid;
    } cache_line_t;

    typedef struct packed {
        logic [DCACHE_TAG_WIDTH/8-1:0]  tag;
        logic [DCACHE_LINE_WIDTH/8-1:0] data;
        logic [DCACHE_SET_ASSOC-1:0]    vldrty;
    } cl_be_t;

endpackage

// File: rtl/dcache_prio_arb.sv
// Fixed-priority one-hot arbiter; index 0 wins.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; losers simply see no grant and must hold their request.
module dcache_prio_arb #(
    parameter int NR_PORTS = 4,
    parameter int SEL_W    = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
    input  logic [NR_PORTS-1:0] req_i,
    output logic [NR_PORTS-1:0] gnt_o,
    output logic [SEL_W-1:0]    sel_o
);

    // Walk from the lowest priority upward so the last hit is the lowest index.
    always_comb begin
        gnt_o = '0;
        sel_o = '0;
        for (int i = NR_PORTS - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                sel_o    = i[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dcache_tag_arb_cmp.sv
// Arbitrates requesters onto the shared way SRAMs and checks tag hits.
// Latency: grant/SRAM controls 0 cycles; hit vector 1 cycle after grant.
// Backpressure: strict priority, losers stall by holding req_i; no fairness.
module dcache_tag_arb_cmp
    import dcache_pkg::*;
#(
    parameter int NR_PORTS   = 4,
    parameter int ADDR_WIDTH = DCACHE_INDEX_WIDTH,
    parameter int SET_ASSOC  = DCACHE_SET_ASSOC,
    parameter int TAG_WIDTH  = DCACHE_TAG_WIDTH
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NR_PORTS-1:0][SET_ASSOC-1:0]     req_i,
    output logic [NR_PORTS-1:0]                    gnt_o,
    input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]    addr_i,
    input  cache_line_t [NR_PORTS-1:0]             wdata_i,
    input  logic [NR_PORTS-1:0]                    we_i,
    input  cl_be_t [NR_PORTS-1:0]                  be_i,
    input  logic [NR_PORTS-1:0][TAG_WIDTH-1:0]     tag_i,
    output cache_line_t [SET_ASSOC-1:0]            rdata_o,
    output logic [SET_ASSOC-1:0]                   hit_way_o,
    output logic [SET_ASSOC-1:0]                   req_o,
    output logic [ADDR_WIDTH-1:0]                  addr_o,
    output cache_line_t                            wdata_o,
    output logic                                   we_o,
    output cl_be_t                                 be_o,
    input  cache_line_t [SET_ASSOC-1:0]            rdata_i
);

    localparam int SEL_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    logic [NR_PORTS-1:0]  port_req;
    logic [SEL_W-1:0]     sel;
    logic [NR_PORTS-1:0]  id_q;
    logic [TAG_WIDTH-1:0] sel_tag;

    always_comb begin
        port_req = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            port_req[i] = |req_i[i];
        end
    end

    dcache_prio_arb #(
        .NR_PORTS (NR_PORTS),
        .SEL_W    (SEL_W)
    ) u_arb (
        .req_i (port_req),
        .gnt_o (gnt_o),
        .sel_o (sel)
    );

    // SRAM controls are forced to zero when idle so no stray write can leak.
    always_comb begin
        req_o   = '0;
        addr_o  = '0;
        wdata_o = '0;
        we_o    = 1'b0;
        be_o    = '0;
        if (|gnt_o) begin
            req_o   = req_i[sel];
            addr_o  = addr_i[sel];
            wdata_o = wdata_i[sel];
            we_o    = we_i[sel];
            be_o    = be_i[sel];
        end
    end

    // Remembers which port owns the SRAM read data arriving next cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q <= '0;
        end else begin
            id_q <= gnt_o;
        end
    end

    always_comb begin
        sel_tag = '0;
        for (int k = 0; k < NR_PORTS; k++) begin
            sel_tag = sel_tag | (tag_i[k] & {TAG_WIDTH{id_q[k]}});
        end
    end

    always_comb begin
        hit_way_o = '0;
        for (int j = 0; j < SET_ASSOC; j++) begin
            hit_way_o[j] = (sel_tag == rdata_i[j].tag) && rdata_i[j].valid && (|id_q);
        end
    end

    assign rdata_o = rdata_i;

endmodule

// File: tb/tb_dcache_tag_arb_cmp.sv
// Directed bench for dcache_tag_arb_cmp: arbitration, hit compare, back-to-back, reset.
module tb_dcache_tag_arb_cmp;
    import dcache_pkg::*;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [3:0][7:0]        req_i;
    logic [3:0]             gnt_o;
    logic [3:0][11:0]       addr_i;
    cache_line_t [3:0]      wdata_i;
    logic [3:0]             we_i;
    cl_be_t [3:0]           be_i;
    logic [3:0][43:0]       tag_i;
    cache_line_t [7:0]      rdata_o;
    logic [7:0]             hit_way_o;
    logic [7:0]             req_o;
    logic [11:0]            addr_o;
    cache_line_t            wdata_o;
    logic                   we_o;
    cl_be_t                 be_o;
    cache_line_t [7:0]      rdata_i;

    int n_cmp = 0;
    int n_err = 0;

    dcache_tag_arb_cmp dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .gnt_o     (gnt_o),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .we_i      (we_i),
        .be_i      (be_i),
        .tag_i     (tag_i),
        .rdata_o   (rdata_o),
        .hit_way_o (hit_way_o),
        .req_o     (req_o),
        .addr_o    (addr_o),
        .wdata_o   (wdata_o),
        .we_o      (we_o),
        .be_o      (be_o),
        .rdata_i   (rdata_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        req_i   = '0;
        addr_i  = '0;
        wdata_i = '0;
        we_i    = '0;
        be_i    = '0;
        tag_i   = '0;
        rdata_i = '0;
    endtask

    // Every way holds a distinct non-matching tag 0x200+j and is valid.
    task automatic fill_ways();
        for (int j = 0; j < 8; j++) begin
            rdata_i[j].tag   = 44'h200 + 44'(j);
            rdata_i[j].data  = 128'h1000 + 128'(j);
            rdata_i[j].valid = 1'b1;
            rdata_i[j].dirty = j[0];
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1'b1;
        step();
        step();
        fill_ways();
        rdata_i[0].tag = 44'h0;
        #1;
        n_cmp++;
        if (gnt_o !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_gnt: got %b expected %b", gnt_o, 4'b0000);
        end
        n_cmp++;
        if (hit_way_o !== 8'h00) begin
            n_err++;
            $display("FAIL reset_hit: got %h expected %h", hit_way_o, 8'h00);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_priority();
        clear_inputs();
        req_i[1]         = 8'h01;
        req_i[3]         = 8'hFF;
        addr_i[1]        = 12'h111;
        addr_i[3]        = 12'h333;
        we_i[1]          = 1'b0;
        we_i[3]          = 1'b1;
        be_i[1].data     = 16'h00FF;
        be_i[3].data     = 16'hFF00;
        wdata_i[1].tag   = 44'hABC;
        wdata_i[3].tag   = 44'hDEF;
        #1;
        n_cmp++;
        if (gnt_o !== 4'b0010) begin
            n_err++;
            $display("FAIL prio_gnt: got %b expected %b", gnt_o, 4'b0010);
        end
        n_cmp++;
        if (req_o !== 8'h01) begin
            n_err++;
            $display("FAIL prio_req: got %h expected %h", req_o, 8'h01);
        end
        n_cmp++;
        if (addr_o !== 12'h111) begin
            n_err++;
            $display("FAIL prio_addr: got %h expected %h", addr_o, 12'h111);
        end
        n_cmp++;
        if (we_o !== 1'b0 || be_o.data !== 16'h00FF || wdata_o.tag !== 44'hABC) begin
            n_err++;
            $display("FAIL prio_wr: got we=%b be=%h tag=%h expected we=0 be=00ff tag=abc",
                     we_o, be_o.data, wdata_o.tag);
        end
        // With port 1 gone, port 3 takes the SRAM.
        req_i[1] = 8'h00;
        #1;
        n_cmp++;
        if (gnt_o !== 4'b1000 || req_o !== 8'hFF || addr_o !== 12'h333 || we_o !== 1'b1) begin
            n_err++;
            $display("FAIL prio_port3: got gnt=%b req=%h addr=%h we=%b expected 1000 ff 333 1",
                     gnt_o, req_o, addr_o, we_o);
        end
        step();
    endtask

    task automatic test_hit(input logic way5_valid, input logic [7:0] exp_hit);
        clear_inputs();
        req_i[2]  = 8'h01;
        addr_i[2] = 12'h040;
        #1;
        n_cmp++;
        if (gnt_o !== 4'b0100 || addr_o !== 12'h040) begin
            n_err++;
            $display("FAIL hit_grant: got gnt=%b addr=%h expected 0100 040", gnt_o, addr_o);
        end
        step();
        req_i    = '0;
        tag_i[0] = 44'h201;
        tag_i[1] = 44'h202;
        tag_i[2] = 44'h123;
        tag_i[3] = 44'h203;
        fill_ways();
        rdata_i[5].tag   = 44'h123;
        rdata_i[5].valid = way5_valid;
        #1;
        n_cmp++;
        if (hit_way_o !== exp_hit) begin
            n_err++;
            $display("FAIL hit_vec(valid=%b): got %h expected %h", way5_valid, hit_way_o, exp_hit);
        end
        n_cmp++;
        if (rdata_o[5].tag !== 44'h123 || rdata_o[3].data !== 128'h1003 || rdata_o[5].valid !== way5_valid) begin
            n_err++;
            $display("FAIL rdata_pass: got tag5=%h data3=%h v5=%b expected 123 1003 %b",
                     rdata_o[5].tag, rdata_o[3].data, rdata_o[5].valid, way5_valid);
        end
        step();
    endtask

    task automatic test_idle();
        clear_inputs();
        step();
        for (int j = 0; j < 8; j++) rdata_i[j].valid = 1'b1;
        #1;
        n_cmp++;
        if (gnt_o !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_gnt: got %b expected %b", gnt_o, 4'b0000);
        end
        n_cmp++;
        if (hit_way_o !== 8'h00) begin
            n_err++;
            $display("FAIL idle_hit: got %h expected %h", hit_way_o, 8'h00);
        end
        n_cmp++;
        if (req_o !== 8'h00 || addr_o !== 12'h000 || we_o !== 1'b0 || be_o !== '0 || wdata_o !== '0) begin
            n_err++;
            $display("FAIL idle_ctrl: got req=%h addr=%h we=%b expected all zero", req_o, addr_o, we_o);
        end
        step();
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        req_i[0] = 8'h01;
        step();
        req_i[0] = 8'h00;
        req_i[3] = 8'h02;
        tag_i[0] = 44'hAAA;
        tag_i[3] = 44'hBBB;
        fill_ways();
        rdata_i[1].tag = 44'hAAA;
        rdata_i[6].tag = 44'hBBB;
        #1;
        n_cmp++;
        if (gnt_o !== 4'b1000) begin
            n_err++;
            $display("FAIL b2b_gnt: got %b expected %b", gnt_o, 4'b1000);
        end
        n_cmp++;
        if (hit_way_o !== 8'h02) begin
            n_err++;
            $display("FAIL b2b_hit_port0: got %h expected %h", hit_way_o, 8'h02);
        end
        step();
        req_i = '0;
        #1;
        n_cmp++;
        if (hit_way_o !== 8'h40) begin
            n_err++;
            $display("FAIL b2b_hit_port3: got %h expected %h", hit_way_o, 8'h40);
        end
        step();
    endtask

    task automatic test_reset_mid(input logic do_rst, input logic [7:0] exp_hit);
        clear_inputs();
        req_i[1] = 8'h04;
        rst_i    = do_rst;
        #1;
        n_cmp++;
        if (gnt_o !== 4'b0010 || req_o !== 8'h04) begin
            n_err++;
            $display("FAIL rstmid_gnt(rst=%b): got gnt=%b req=%h expected 0010 04", do_rst, gnt_o, req_o);
        end
        step();
        rst_i    = 1'b0;
        req_i    = '0;
        tag_i[1] = 44'hCCC;
        fill_ways();
        rdata_i[2].tag = 44'hCCC;
        #1;
        n_cmp++;
        if (hit_way_o !== exp_hit) begin
            n_err++;
            $display("FAIL rstmid_hit(rst=%b): got %h expected %h", do_rst, hit_way_o, exp_hit);
        end
        step();
    endtask

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        test_reset();
        test_priority();
        test_hit(1'b1, 8'h20);
        test_hit(1'b0, 8'h00);
        test_idle();
        test_back_to_back();
        test_reset_mid(1'b1, 8'h00);
        test_reset_mid(1'b0, 8'h04);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
